uart_tx_sequencer: RTL and testbench
====================================

// Module: uart_tx_sequencer
// PURPOSE
//  Frame controller for the UART transmitter, directly upstream of the TX output mux.
//  Accepts one parallel word per handshake and drives Mux_Sel, ser_data and Par_Bit.
//  The mux then emits start bit, data LSB-first, optional parity, and stop bit(s) on TX_OUT.
//  One bit is emitted per CLK cycle; CLK is the baud-rate clock.
// PARAMETERS
//  DATA_WIDTH  8  word width in bits; legal range 5..9
//  STOP_BITS   1  stop-bit cycles per frame; legal values 1 or 2
// PORTS
//  CLK         in   1           baud clock; all state updates on rising edge
//  RST         in   1           synchronous reset, active-high
//  P_DATA      in   DATA_WIDTH  parallel word to transmit
//  Data_Valid  in   1           request; P_DATA/PAR_EN/PAR_TYP valid while high
//  PAR_EN      in   1           1 = insert parity bit after data
//  PAR_TYP     in   1           0 = even parity, 1 = odd parity
//  Mux_Sel     out  3           0 start, 1 stop, 2 ser_data, 3 parity, 4 idle/no-trans
//  ser_data    out  1           current data bit (shift register LSB)
//  Par_Bit     out  1           parity of latched word
//  Busy        out  1           high while a frame is in progress
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high.
//   - State goes to IDLE.
//   - Mux_Sel=4, Busy=0, ser_data=0, Par_Bit=0.
//   - Bit counter, stop counter and shift register are cleared.
//   - Reset asserted mid-frame aborts the frame. On the next cycle the outputs equal the reset values; no partial resume.
//  FSM states and transitions:
//   - IDLE -> START: on an edge where Data_Valid=1 while in IDLE.
//     That edge latches P_DATA into the shift register, computes Par_Bit, and latches PAR_EN.
//   - START -> DATA: after 1 cycle.
//   - DATA -> PARITY if the latched PAR_EN=1, else DATA -> STOP: after DATA_WIDTH cycles.
//     Bit counter runs 0..DATA_WIDTH-1 and wraps to 0 on exit.
//   - PARITY -> STOP: after 1 cycle.
//   - STOP -> IDLE: after STOP_BITS cycles.
//  Outputs are Moore-decoded from state: IDLE=4, START=0, DATA=2, PARITY=3, STOP=1.
//  Busy=1 in every state except IDLE.
//  Data path:
//   - ser_data = shift_reg[0], stable across the whole bit cycle.
//   - The shift register moves right by one at the end of each DATA cycle, so the LSB is sent first.
//  Parity:
//   - Par_Bit = ^P_DATA when PAR_TYP=0, ~^P_DATA when PAR_TYP=1, taken from the accepted word.
//   - Par_Bit is held constant from acceptance until the next acceptance or reset.
//  Handshake:
//   - Data_Valid is sampled only in IDLE.
//   - Data_Valid while Busy=1 is ignored and the word is dropped; no queueing.
//   - Latency: acceptance edge -> start bit on the following cycle.
//  Frame length = 1 + DATA_WIDTH + PAR_EN + STOP_BITS cycles.
//   - Back-to-back transfer: with Data_Valid held high, a minimum of 1 IDLE cycle separates frames.
//  Input changes after acceptance (P_DATA, PAR_EN, PAR_TYP) do not affect the frame in flight.
// TESTING
//  T1: 0xA5, PAR_EN=1, PAR_TYP=0
//      -> line after mux = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Par_Bit=0.
//      -> Busy high for exactly 11 cycles, then Mux_Sel=4.
//  T2: 0xA5, PAR_EN=1, PAR_TYP=1 -> same frame but parity cycle = 1.
//  T3: 0x3C, PAR_EN=0
//      -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1; Mux_Sel never equals 3.
//  T4: pulse Data_Valid with 0x55 during the DATA state of a 0xFF frame
//      -> 0xFF frame completes unchanged; 0x55 is never sent.
//  T5: assert RST for 1 cycle at data bit 3
//      -> next cycle Mux_Sel=4, Busy=0; a new 0x0F request then yields a clean full frame.
//  T6: Data_Valid held high continuously, STOP_BITS=2
//      -> 12-cycle frames (PAR_EN=1), each followed by exactly 1 idle cycle (Mux_Sel=4).

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// Frame controller for the UART transmitter: sequences start, data (LSB first),
// optional parity and stop bits by driving the TX output mux select one bit per baud clock.
module uart_tx_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [2:0]            Mux_Sel,
  output logic                  ser_data,
  output logic                  Par_Bit,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] SEL_START  = 3'd0;
  localparam logic [2:0] SEL_STOP   = 3'd1;
  localparam logic [2:0] SEL_DATA   = 3'd2;
  localparam logic [2:0] SEL_PARITY = 3'd3;
  localparam logic [2:0] SEL_IDLE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                  stop_cnt_reg, stop_cnt_next;
  logic [DATA_WIDTH-1:0] data_sr_reg, data_sr_next;
  logic                  par_bit_reg, par_bit_next;
  logic                  par_en_reg, par_en_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      data_sr_reg  <= '0;
      par_bit_reg  <= 1'b0;
      par_en_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      data_sr_reg  <= data_sr_next;
      par_bit_reg  <= par_bit_next;
      par_en_reg   <= par_en_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    data_sr_next  = data_sr_reg;
    par_bit_next  = par_bit_reg;
    par_en_next   = par_en_reg;
    Mux_Sel       = SEL_IDLE;

    case (state_reg)
      S_IDLE: begin
        Mux_Sel = SEL_IDLE;
        // Only IDLE looks at the request; anything offered mid-frame is dropped.
        if (Data_Valid) begin
          state_next   = S_START;
          data_sr_next = P_DATA;
          par_bit_next = PAR_TYP ? ~^P_DATA : ^P_DATA;
          par_en_next  = PAR_EN;
        end
      end
      S_START: begin
        Mux_Sel      = SEL_START;
        state_next   = S_DATA;
        bit_cnt_next = '0;
      end
      S_DATA: begin
        Mux_Sel      = SEL_DATA;
        data_sr_next = data_sr_reg >> 1;
        if (bit_cnt_reg == BIT_LAST) begin
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          state_next    = par_en_reg ? S_PARITY : S_STOP;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      S_PARITY: begin
        Mux_Sel       = SEL_PARITY;
        stop_cnt_next = 1'b0;
        state_next    = S_STOP;
      end
      S_STOP: begin
        Mux_Sel = SEL_STOP;
        if (stop_cnt_reg == STOP_LAST) begin
          stop_cnt_next = 1'b0;
          state_next    = S_IDLE;
        end else begin
          stop_cnt_next = stop_cnt_reg + 1'b1;
        end
      end
      default: begin
        Mux_Sel    = SEL_IDLE;
        state_next = S_IDLE;
      end
    endcase
  end

  assign Busy     = (state_reg != S_IDLE);
  assign ser_data = data_sr_reg[0];
  assign Par_Bit  = par_bit_reg;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: frame-level reference model plus
// table vectors, hand-written corner sequences and randomized traffic.
module tb_uart_tx_sequencer;

  localparam int DW = 8;
  localparam int SB = 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid, PAR_EN, PAR_TYP;
  logic [2:0]    Mux_Sel;
  logic          ser_data, Par_Bit, Busy;

  // Second instance with two stop bits, driven independently.
  logic [DW-1:0] p_data2;
  logic          dv2, par_en2, par_typ2;
  logic [2:0]    mux_sel2;
  logic          ser_data2, par_bit2, busy2;

  always #5 CLK = ~CLK;

  uart_tx_sequencer #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Mux_Sel(Mux_Sel),
    .ser_data(ser_data), .Par_Bit(Par_Bit), .Busy(Busy)
  );

  uart_tx_sequencer #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data2), .Data_Valid(dv2),
    .PAR_EN(par_en2), .PAR_TYP(par_typ2), .Mux_Sel(mux_sel2),
    .ser_data(ser_data2), .Par_Bit(par_bit2), .Busy(busy2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the expected line beats still to come, plus current beat.
  typedef struct {
    logic [2:0] sel;
    logic       line;
  } beat_t;

  beat_t      q[$];
  logic [2:0] m_sel  = 3'd4;
  logic       m_line = 1'b1;
  logic       m_par  = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic dut_line();
    case (Mux_Sel)
      3'd0:    return 1'b0;
      3'd1:    return 1'b1;
      3'd2:    return ser_data;
      3'd3:    return Par_Bit;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_accept(input logic [DW-1:0] d, input logic pe, input logic pt);
    logic par;
    par = logic'($countones(d) % 2) ^ pt;
    m_par = par;
    q.delete();
    q.push_back('{3'd0, 1'b0});
    for (int i = 0; i < DW; i++) q.push_back('{3'd2, d[i]});
    if (pe) q.push_back('{3'd3, par});
    for (int i = 0; i < SB; i++) q.push_back('{3'd1, 1'b1});
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic          rst_s, dv_s, pe_s, pt_s;
    logic [DW-1:0] d_s;
    beat_t         b;
    rst_s = RST; dv_s = Data_Valid; pe_s = PAR_EN; pt_s = PAR_TYP; d_s = P_DATA;
    @(posedge CLK);
    if (rst_s) begin
      q.delete();
      m_sel = 3'd4; m_line = 1'b1; m_par = 1'b0;
    end else begin
      if (m_sel == 3'd4 && dv_s) model_accept(d_s, pe_s, pt_s);
      if (q.size() > 0) begin
        b = q.pop_front();
        m_sel = b.sel; m_line = b.line;
      end else begin
        m_sel = 3'd4; m_line = 1'b1;
      end
    end
    #1;
    chk("mux_sel", 16'(Mux_Sel), 16'(m_sel));
    chk("busy", 16'(Busy), 16'(m_sel != 3'd4));
    chk("par_bit", 16'(Par_Bit), 16'(m_par));
    if (m_sel != 3'd4) chk("line", 16'(dut_line()), 16'(m_line));
  endtask

  // Accept one word and record the muxed line until Busy drops.
  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                           output logic [15:0] bits, output int len, output int n_par);
    bits = '0; len = 0; n_par = 0;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    while (Busy && len < 16) begin
      bits[len] = dut_line();
      if (Mux_Sel == 3'd3) n_par++;
      len++;
      step();
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [15:0] exp_bits;
    int         exp_len;
    logic       exp_par;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [15:0] bits;
    int          len, n_par, k, pos;
    logic [2:0]  exp_sel;

    vecs[0] = '{"T1 A5 even", 8'hA5, 1'b1, 1'b0, 16'h054A, 11, 1'b0};
    vecs[1] = '{"T2 A5 odd",  8'hA5, 1'b1, 1'b1, 16'h074A, 11, 1'b1};
    vecs[2] = '{"T3 3C nopar", 8'h3C, 1'b0, 1'b0, 16'h0278, 10, 1'b0};
    vecs[3] = '{"00 odd",     8'h00, 1'b1, 1'b1, 16'h0600, 11, 1'b1};
    vecs[4] = '{"FF nopar",   8'hFF, 1'b0, 1'b0, 16'h03FE, 10, 1'b0};

    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    dv2 = 1'b0; p_data2 = '0; par_en2 = 1'b0; par_typ2 = 1'b0;
    step(); step();
    RST = 1'b0;
    chk("reset_mux_sel", 16'(Mux_Sel), 16'd4);
    chk("reset_busy", 16'(Busy), 16'd0);
    chk("reset_ser_data", 16'(ser_data), 16'd0);
    chk("reset_par_bit", 16'(Par_Bit), 16'd0);
    step();

    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, bits, len, n_par);
      chk({vecs[i].name, " bits"}, bits, vecs[i].exp_bits);
      chk({vecs[i].name, " busy_len"}, 16'(len), 16'(vecs[i].exp_len));
      chk({vecs[i].name, " par_bit"}, 16'(Par_Bit), 16'(vecs[i].exp_par));
      chk({vecs[i].name, " parity_beats"}, 16'(n_par), 16'(vecs[i].pe));
      $display("vector %s: data=%02h line=%0h len=%0d", vecs[i].name, vecs[i].data, bits, len);
      step();
    end

    // T4: request during DATA of a 0xFF frame is dropped.
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    step();
    bits = '0; len = 0;
    while (Busy && len < 16) begin
      bits[len] = dut_line();
      if (len == 3) begin
        P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
      end else begin
        Data_Valid = 1'b0;
      end
      len++;
      step();
    end
    Data_Valid = 1'b0;
    chk("T4 bits", bits, 16'h03FE);
    chk("T4 busy_len", 16'(len), 16'd10);
    step(); step();
    chk("T4 no_second_frame", 16'(Busy), 16'd0);
    chk("T4 par_bit", 16'(Par_Bit), 16'd0);
    $display("sequence T4: line=%0h len=%0d", bits, len);

    // T5: reset at data bit 3, then a clean 0x0F frame.
    P_DATA = 8'h0F; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    step();
    Data_Valid = 1'b0;
    repeat (4) step();
    chk("T5 at_bit3", 16'(Mux_Sel), 16'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("T5 rst_mux_sel", 16'(Mux_Sel), 16'd4);
    chk("T5 rst_busy", 16'(Busy), 16'd0);
    chk("T5 rst_ser_data", 16'(ser_data), 16'd0);
    chk("T5 rst_par_bit", 16'(Par_Bit), 16'd0);
    run_frame(8'h0F, 1'b1, 1'b0, bits, len, n_par);
    chk("T5 bits", bits, 16'h041E);
    chk("T5 busy_len", 16'(len), 16'd11);
    $display("sequence T5: line=%0h len=%0d", bits, len);

    // T6: two stop bits, Data_Valid held high -> 12-cycle frames, 1 idle between.
    p_data2 = 8'h96; par_en2 = 1'b1; par_typ2 = 1'b0; dv2 = 1'b1;
    for (k = 0; k < 39; k++) begin
      step();
      pos = k % 13;
      if (pos == 0) exp_sel = 3'd0;
      else if (pos <= 8) exp_sel = 3'd2;
      else if (pos == 9) exp_sel = 3'd3;
      else if (pos <= 11) exp_sel = 3'd1;
      else exp_sel = 3'd4;
      chk("T6 mux_sel", 16'(mux_sel2), 16'(exp_sel));
      chk("T6 busy", 16'(busy2), 16'(exp_sel != 3'd4));
    end
    dv2 = 1'b0;
    chk("T6 par_bit", 16'(par_bit2), 16'd0);
    $display("sequence T6: 3 back-to-back frames on 2-stop-bit instance");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      Data_Valid = ($urandom_range(0, 2) == 0);
      RST        = ($urandom_range(0, 49) == 0);
      step();
    end
    RST = 1'b0; Data_Valid = 1'b0;
    repeat (14) step();
    $display("random: 400 cycles of randomized traffic");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
